// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter feeding a single fifo. Each winner may keep writing
// for up to MAX_BURST consecutive words before the turn moves on.
module fifo_wr_arbiter #(
    parameter int DATA_SIZE = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
    input  logic                           full,
    output logic [NUM_REQ-1:0]             gnt,
    output logic                           write_to_fifo,
    output logic [DATA_SIZE-1:0]           write_data_in,
    output logic [$clog2(NUM_REQ)-1:0]     owner,
    output logic                           busy
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_inc_s;
    logic [OW-1:0]   sel_s;
    logic            found_s;
    logic [NUM_REQ-1:0]   gnt_s;
    logic [DATA_SIZE-1:0] data_s;

    // Round-robin search starting just after the last-served producer.
    always_comb begin
        found_s = 1'b0;
        sel_s   = {OW{1'b0}};
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found_s && req[(int'(last_q) + k) % NUM_REQ]) begin
                found_s = 1'b1;
                sel_s   = OW'((int'(last_q) + k) % NUM_REQ);
            end else begin
                found_s = found_s;
            end
        end
    end

    assign cnt_inc_s = cnt_q + CW'(1);

    // Next-state and grant decode; full freezes everything.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gnt_s   = {NUM_REQ{1'b0}};
        case (state_q)
            IDLE: begin
                if (!full && found_s) begin
                    gnt_s[sel_s] = 1'b1;
                    owner_d      = sel_s;
                    cnt_d        = CW'(1);
                    if (MAX_BURST == 1) begin
                        last_d = sel_s;
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (full) begin
                    state_d = HOLD;
                end else if (req[owner_q]) begin
                    gnt_s[owner_q] = 1'b1;
                    cnt_d          = cnt_inc_s;
                    if (cnt_inc_s == CW'(MAX_BURST)) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    // Owner let go early: one empty cycle, then rearbitrate.
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Mux the granted producer's word; reset blanks the write path immediately.
    always_comb begin
        data_s = {DATA_SIZE{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            data_s = data_s | ({DATA_SIZE{gnt_s[i]}} & req_data[i*DATA_SIZE +: DATA_SIZE]);
        end
        if (reset) begin
            gnt           = gnt_s;
            write_data_in = data_s;
        end else begin
            gnt           = {NUM_REQ{1'b0}};
            write_data_in = {DATA_SIZE{1'b0}};
        end
        write_to_fifo = |gnt;
    end

    // State registers; last-served starts at NUM_REQ-1 so producer 0 wins first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= {OW{1'b0}};
            last_q  <= OW'(NUM_REQ - 1);
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign owner = owner_q;
    assign busy  = (state_q == HOLD);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with default parameters (8-bit, 4 producers, burst 4).
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        full;
    logic [3:0]  gnt;
    logic        write_to_fifo;
    logic [7:0]  write_data_in;
    logic [1:0]  owner;
    logic        busy;

    int n_cmp;
    int n_bad;

    fifo_wr_arbiter #(.DATA_SIZE(8), .NUM_REQ(4), .MAX_BURST(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_data      (req_data),
        .full          (full),
        .gnt           (gnt),
        .write_to_fifo (write_to_fifo),
        .write_data_in (write_data_in),
        .owner         (owner),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = 4'b0000;
        full  = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    task automatic set_words(input logic [7:0] base);
        for (int i = 0; i < 4; i++) begin
            req_data[i*8 +: 8] = base + 8'(i);
        end
    endtask

    logic [7:0] wr_log [0:7];
    int         wr_cnt;

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        reset    = 1'b0;
        req      = 4'b1111;
        req_data = 32'h0;
        full     = 1'b0;
        set_words(8'hC0);

        // Reset holds outputs quiet even with every producer requesting.
        cyc();
        cyc();
        #1;
        check_eq("rst_gnt", {28'h0, gnt}, 32'h0);
        check_eq("rst_wr", {31'h0, write_to_fifo}, 32'h0);
        check_eq("rst_data", {24'h0, write_data_in}, 32'h0);
        check_eq("rst_busy", {31'h0, busy}, 32'h0);
        check_eq("rst_owner", {30'h0, owner}, 32'h0);
        reset = 1'b1;
        #1;
        check_eq("rel_gnt", {28'h0, gnt}, 32'h1);

        // All requesting: four-word bursts rotating 0,1,2,3,0.
        for (int k = 0; k < 17; k++) begin
            int p;
            p = (k / 4) % 4;
            check_eq("rr_gnt", {28'h0, gnt}, 32'h1 << p);
            check_eq("rr_data", {24'h0, write_data_in}, 32'hC0 + p);
            check_eq("rr_busy", {31'h0, busy}, (k % 4 == 0) ? 32'h0 : 32'h1);
            cyc();
        end

        // Single producer 2 streams A1..A6 without a bubble.
        do_reset();
        req = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            req_data[16 +: 8] = 8'hA1 + 8'(k);
            #1;
            check_eq("sp_gnt", {28'h0, gnt}, 32'h4);
            check_eq("sp_data", {24'h0, write_data_in}, 32'hA1 + k);
            check_eq("sp_busy", {31'h0, busy}, (k == 0 || k == 4) ? 32'h0 : 32'h1);
            cyc();
        end

        // Backpressure in the middle of producer 1's burst.
        do_reset();
        req = 4'b0110;
        set_words(8'h50);
        for (int k = 0; k < 2; k++) begin
            #1;
            check_eq("bp_gnt_pre", {28'h0, gnt}, 32'h2);
            cyc();
        end
        full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("bp_gnt_full", {28'h0, gnt}, 32'h0);
            check_eq("bp_wr_full", {31'h0, write_to_fifo}, 32'h0);
            check_eq("bp_owner", {30'h0, owner}, 32'h1);
            check_eq("bp_busy", {31'h0, busy}, 32'h1);
            cyc();
        end
        full = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            check_eq("bp_gnt_post", {28'h0, gnt}, 32'h2);
            check_eq("bp_data", {24'h0, write_data_in}, 32'h51);
            cyc();
        end
        #1;
        check_eq("bp_next", {28'h0, gnt}, 32'h4);

        // Owner 0 drops after two words: one bubble, then producer 1.
        do_reset();
        req = 4'b1011;
        #1;
        check_eq("er_gnt0", {28'h0, gnt}, 32'h1);
        cyc();
        check_eq("er_gnt1", {28'h0, gnt}, 32'h1);
        cyc();
        req = 4'b1010;
        #1;
        check_eq("er_bubble", {28'h0, gnt}, 32'h0);
        check_eq("er_bubble_wr", {31'h0, write_to_fifo}, 32'h0);
        cyc();
        check_eq("er_next", {28'h0, gnt}, 32'h2);

        // Reset mid-burst aborts at once and restarts at producer 0.
        do_reset();
        req = 4'b0100;
        cyc();
        cyc();
        check_eq("mr_owner_pre", {30'h0, owner}, 32'h2);
        reset = 1'b0;
        req   = 4'b1111;
        #1;
        check_eq("mr_gnt", {28'h0, gnt}, 32'h0);
        check_eq("mr_wr", {31'h0, write_to_fifo}, 32'h0);
        check_eq("mr_owner", {30'h0, owner}, 32'h0);
        check_eq("mr_busy", {31'h0, busy}, 32'h0);
        cyc();
        reset = 1'b1;
        #1;
        check_eq("mr_restart", {28'h0, gnt}, 32'h1);

        // Depth-4 fifo with no reads fills with producer 0's 10..13, then stalls.
        do_reset();
        req    = 4'b0011;
        wr_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            req_data[0 +: 8] = 8'h10 + 8'(wr_cnt);
            req_data[8 +: 8] = 8'h20;
            full = (wr_cnt >= 4);
            #1;
            if (write_to_fifo) begin
                if (wr_cnt < 8) wr_log[wr_cnt] = write_data_in;
                wr_cnt++;
            end
            cyc();
        end
        check_eq("ff_count", 32'(wr_cnt), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq("ff_order", {24'h0, wr_log[i]}, 32'h10 + i);
        end
        check_eq("ff_gnt_full", {28'h0, gnt}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
